// File: rtl/dpram_initiator.sv
// dpram_initiator: writes seed+i over a wrapping address window, reads it back and checks
// each word RD_LATENCY cycles after its rd_cs cycle. Define DPRAM_INITIATOR_ECC_CNT_EN to build the ECC event counters.
module dpram_initiator #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  wr_cs,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_cs,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  ecccorr,
    input  logic                  eccderr,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt,
    output logic [15:0]           ecccorr_cnt,
    output logic [15:0]           eccderr_cnt,
    output logic                  first_err_vld,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [2:0]            dbg_state
);

    // Handshake: start is a single-cycle request honoured only in IDLE (ignored while busy);
    // busy covers the whole run and done pulses once in its final cycle.
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [DATA_WIDTH-1:0]   seed_q;
    logic [ADDR_WIDTH:0]     n_q;
    logic [ADDR_WIDTH:0]     idx_q;
    logic                    wr_cs_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic                    rd_cs_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [DATA_WIDTH-1:0]   rd_exp_q;
    logic                    busy_q;
    logic                    done_q;
    logic [15:0]             err_cnt_q, err_cnt_d;
    logic                    first_err_vld_q;
    logic [ADDR_WIDTH-1:0]   first_err_addr_q;

    logic [RD_LATENCY-1:0]   pipe_vld_q;
    logic [ADDR_WIDTH-1:0]   pipe_addr_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_exp_q  [RD_LATENCY];

    logic                    start_acc;
    logic                    chk_vld;
    logic                    chk_miss;
    logic [RD_LATENCY-1:0]   upstream;
    logic                    drain_empty;

    assign start_acc = (state_q == S_IDLE) && start;

    // The last pipeline stage is compared on this edge, so only earlier stages keep DRAIN waiting.
    always_comb begin
        chk_vld   = pipe_vld_q[RD_LATENCY-1];
        chk_miss  = chk_vld && (rd_data !== pipe_exp_q[RD_LATENCY-1]);
        err_cnt_d = err_cnt_q;
        if (chk_miss && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
        upstream = pipe_vld_q;
        upstream[RD_LATENCY-1] = 1'b0;
        drain_empty = (upstream == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            base_q           <= '0;
            seed_q           <= '0;
            n_q              <= '0;
            idx_q            <= '0;
            wr_cs_q          <= 1'b0;
            wr_addr_q        <= '0;
            wr_data_q        <= '0;
            rd_cs_q          <= 1'b0;
            rd_addr_q        <= '0;
            rd_exp_q         <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_cnt_q        <= '0;
            first_err_vld_q  <= 1'b0;
            first_err_addr_q <= '0;
            pipe_vld_q       <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_addr_q[i] <= '0;
                pipe_exp_q[i]  <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= rd_cs_q;
            pipe_addr_q[0] <= rd_addr_q;
            pipe_exp_q[0]  <= rd_exp_q;
            for (int i = RD_LATENCY-1; i > 0; i--) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
                pipe_exp_q[i]  <= pipe_exp_q[i-1];
            end

            err_cnt_q <= err_cnt_d;
            if (chk_miss && !first_err_vld_q) begin
                first_err_vld_q  <= 1'b1;
                first_err_addr_q <= pipe_addr_q[RD_LATENCY-1];
            end
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q          <= base_addr;
                        seed_q          <= seed;
                        n_q             <= num_words;
                        busy_q          <= 1'b1;
                        err_cnt_q       <= '0;
                        first_err_vld_q <= 1'b0;
                        if (num_words == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q   <= S_WRITE;
                            wr_cs_q   <= 1'b1;
                            wr_addr_q <= base_addr;
                            wr_data_q <= seed;
                            idx_q     <= (ADDR_WIDTH+1)'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (idx_q == n_q) begin
                        state_q   <= S_READ;
                        wr_cs_q   <= 1'b0;
                        rd_cs_q   <= 1'b1;
                        rd_addr_q <= base_q;
                        rd_exp_q  <= seed_q;
                        idx_q     <= (ADDR_WIDTH+1)'(1);
                    end else begin
                        wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
                        wr_data_q <= wr_data_q + DATA_WIDTH'(1);
                        idx_q     <= idx_q + (ADDR_WIDTH+1)'(1);
                    end
                end
                S_READ: begin
                    if (idx_q == n_q) begin
                        state_q <= S_DRAIN;
                        rd_cs_q <= 1'b0;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
                        rd_exp_q  <= rd_exp_q + DATA_WIDTH'(1);
                        idx_q     <= idx_q + (ADDR_WIDTH+1)'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_empty) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    // An empty run arrives here with done still low and spends one cycle raising it.
                    if (done_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef DPRAM_INITIATOR_ECC_CNT_EN
    logic [15:0] ecccorr_cnt_q;
    logic [15:0] eccderr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            ecccorr_cnt_q <= '0;
            eccderr_cnt_q <= '0;
        end else if (chk_vld) begin
            if ((ecccorr === 1'b1) && (ecccorr_cnt_q != 16'hFFFF)) begin
                ecccorr_cnt_q <= ecccorr_cnt_q + 16'd1;
            end
            if ((eccderr === 1'b1) && (eccderr_cnt_q != 16'hFFFF)) begin
                eccderr_cnt_q <= eccderr_cnt_q + 16'd1;
            end
        end
    end

    assign ecccorr_cnt = ecccorr_cnt_q;
    assign eccderr_cnt = eccderr_cnt_q;
`else
    logic unused_ecc;
    assign unused_ecc  = ecccorr ^ eccderr;
    assign ecccorr_cnt = '0;
    assign eccderr_cnt = '0;
`endif

    assign wr_cs          = wr_cs_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign rd_cs          = rd_cs_q;
    assign rd_addr        = rd_addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_vld  = first_err_vld_q;
    assign first_err_addr = first_err_addr_q;
    assign dbg_state      = state_q;

endmodule
